// File: rtl/model_memory_dump.sv
// model_memory_dump: reads back the index/position/normal/material memories and serialises them in the loader byte format.
// Optional trailing XOR checksum byte is enabled by defining MODEL_DUMP_CHECKSUM_EN.
module model_memory_dump #(
  parameter int INDICES_WIDTH  = 36,
  parameter int BRAM_WIDTH     = 96,
  parameter int INDEX_DEPTH    = 8192,
  parameter int VERTEX_DEPTH   = 2048,
  parameter int MATERIAL_DEPTH = 32,
  parameter int READ_LATENCY   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [1:0]               section_out,
  output logic [15:0]              addr_out,
  input  logic [INDICES_WIDTH-1:0] index_data_in,
  input  logic [BRAM_WIDTH-1:0]    position_data_in,
  input  logic [BRAM_WIDTH-1:0]    normal_data_in,
  input  logic [BRAM_WIDTH-1:0]    material_data_in,
  output logic [7:0]               byte_out,
  output logic                     valid_out,
  input  logic                     ready_in
);
  localparam int IB = (INDICES_WIDTH + 7) / 8;
  localparam int WB = BRAM_WIDTH / 8;
  localparam logic [BRAM_WIDTH-1:0] IDX_ONES = {{INDICES_WIDTH{1'b1}}, {(BRAM_WIDTH-INDICES_WIDTH){1'b0}}};
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, CSUM, DONE} state_t;
`ifdef MODEL_DUMP_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = DONE;
`endif
  state_t state, state_nx;
  logic [BRAM_WIDTH-1:0] shift, word;
  logic [3:0] bcnt;
  logic [2:0] cnt;
  logic stop, word_stop, hs, last_byte, word_done;
  logic [7:0] csum;
  logic [15:0] last_addr;
  always_comb begin
    last_addr = section_out == 2'd0 ? 16'(INDEX_DEPTH-1) : section_out == 2'd3 ? 16'(MATERIAL_DEPTH-1) : 16'(VERTEX_DEPTH-1);
    word = section_out == 2'd0 ? {index_data_in, {(BRAM_WIDTH-INDICES_WIDTH){1'b0}}} :
           section_out == 2'd1 ? position_data_in : section_out == 2'd2 ? normal_data_in : material_data_in;
    word_stop = section_out == 2'd0 ? &index_data_in : &word;
    valid_out = state == SEND || state == CSUM;
    hs = valid_out && ready_in;
    last_byte = bcnt == (section_out == 2'd0 ? 4'(IB-1) : 4'(WB-1));
    word_done = state == SEND && hs && last_byte;
    byte_out = state == SEND ? shift[BRAM_WIDTH-1 -: 8] : state == CSUM ? csum : 8'h00;
    busy_out = state != IDLE && state != DONE;
    done_out = state == DONE;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_in) state_nx = READ;
      READ: state_nx = WAIT;
      WAIT: if (cnt == 3'd0) state_nx = SEND;
      SEND: if (word_done && (stop || addr_out != last_addr)) state_nx = stop && section_out == 2'd3 ? TAIL : READ;
      CSUM: if (hs) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in)
    if (rst_in) state <= IDLE;
    else state <= state_nx;
  // A depth-bound word without a stop marker stays in SEND and reloads an all-ones word in place.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      section_out <= 2'd0;
      addr_out <= 16'd0;
      shift <= '0;
      bcnt <= 4'd0;
      cnt <= 3'd0;
      stop <= 1'b0;
      csum <= 8'h00;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          section_out <= 2'd0;
          addr_out <= 16'd0;
          csum <= 8'h00;
        end
        READ: cnt <= 3'(READ_LATENCY-1);
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            shift <= word;
            stop <= word_stop;
            bcnt <= 4'd0;
          end
        end
        SEND: if (hs) begin
          shift <= shift << 8;
          bcnt <= bcnt + 4'd1;
          csum <= csum ^ byte_out;
          if (last_byte) begin
            if (stop) begin
              if (section_out != 2'd3) begin
                section_out <= section_out + 2'd1;
                addr_out <= 16'd0;
              end
            end else if (addr_out == last_addr) begin
              shift <= section_out == 2'd0 ? IDX_ONES : '1;
              stop <= 1'b1;
              bcnt <= 4'd0;
            end else addr_out <= addr_out + 16'd1;
          end
        end
        DONE: begin
          section_out <= 2'd0;
          addr_out <= 16'd0;
        end
        default: ;
      endcase
    end
  end
endmodule
